// File: rtl/decode_dispatch_unit_pkg.sv
// Shared definitions for the decode/dispatch unit: RV32I opcode/funct constants,
// the op_type encoding carried to ROB/RS/LSB, and the "operand ready" tag value.
package decode_dispatch_unit_pkg;

  localparam int XLEN      = 32;
  localparam int REG_W     = 5;
  localparam int EMPTY_TAG = 0;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [5:0] {
    OP_EMPTY = 6'd0,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
    OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
  } op_t;

endpackage

// File: rtl/decode_dispatch_unit_inst_decode.sv
// Combinational RV32I decoder for the instruction-queue head: op_type, immediate
// and the operand/destination usage flags. Anything unrecognised decodes to OP_EMPTY.
module decode_dispatch_unit_inst_decode
  import decode_dispatch_unit_pkg::*;
(
  input  logic [31:0] inst_i,
  output op_t         op_o,
  output logic [31:0] imm_o,
  output logic        is_ls_o,
  output logic        uses_rs1_o,
  output logic        uses_rs2_o,
  output logic        writes_rd_o
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode = inst_i[6:0];
  assign f3     = inst_i[14:12];
  assign f7     = inst_i[31:25];

  always_comb begin
    op_o        = OP_EMPTY;
    imm_o       = '0;
    is_ls_o     = 1'b0;
    uses_rs1_o  = 1'b0;
    uses_rs2_o  = 1'b0;
    writes_rd_o = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        op_o        = (opcode == OPC_LUI) ? OP_LUI : OP_AUIPC;
        imm_o       = {inst_i[31:12], 12'b0};
        writes_rd_o = 1'b1;
      end
      OPC_JAL: begin
        op_o        = OP_JAL;
        imm_o       = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
        writes_rd_o = 1'b1;
      end
      OPC_JALR: begin
        if (f3 == 3'b000) op_o = OP_JALR;
        imm_o       = {{20{inst_i[31]}}, inst_i[31:20]};
        uses_rs1_o  = 1'b1;
        writes_rd_o = 1'b1;
      end
      OPC_BRANCH: begin
        case (f3)
          3'b000:  op_o = OP_BEQ;
          3'b001:  op_o = OP_BNE;
          3'b100:  op_o = OP_BLT;
          3'b101:  op_o = OP_BGE;
          3'b110:  op_o = OP_BLTU;
          3'b111:  op_o = OP_BGEU;
          default: op_o = OP_EMPTY;
        endcase
        imm_o      = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
        uses_rs1_o = 1'b1;
        uses_rs2_o = 1'b1;
      end
      OPC_LOAD: begin
        case (f3)
          3'b000:  op_o = OP_LB;
          3'b001:  op_o = OP_LH;
          3'b010:  op_o = OP_LW;
          3'b100:  op_o = OP_LBU;
          3'b101:  op_o = OP_LHU;
          default: op_o = OP_EMPTY;
        endcase
        imm_o       = {{20{inst_i[31]}}, inst_i[31:20]};
        is_ls_o     = 1'b1;
        uses_rs1_o  = 1'b1;
        writes_rd_o = 1'b1;
      end
      OPC_STORE: begin
        case (f3)
          3'b000:  op_o = OP_SB;
          3'b001:  op_o = OP_SH;
          3'b010:  op_o = OP_SW;
          default: op_o = OP_EMPTY;
        endcase
        imm_o      = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
        is_ls_o    = 1'b1;
        uses_rs1_o = 1'b1;
        uses_rs2_o = 1'b1;
      end
      OPC_OPIMM: begin
        imm_o       = {{20{inst_i[31]}}, inst_i[31:20]};
        uses_rs1_o  = 1'b1;
        writes_rd_o = 1'b1;
        case (f3)
          3'b000: op_o = OP_ADDI;
          3'b010: op_o = OP_SLTI;
          3'b011: op_o = OP_SLTIU;
          3'b100: op_o = OP_XORI;
          3'b110: op_o = OP_ORI;
          3'b111: op_o = OP_ANDI;
          3'b001: if (f7 == F7_BASE) op_o = OP_SLLI;
          3'b101: begin
            if (f7 == F7_BASE)     op_o = OP_SRLI;
            else if (f7 == F7_ALT) op_o = OP_SRAI;
          end
          default: op_o = OP_EMPTY;
        endcase
        // Shifts carry the bare shamt, not the sign-extended I-immediate.
        if (f3 == 3'b001 || f3 == 3'b101) imm_o = {27'b0, inst_i[24:20]};
      end
      OPC_OP: begin
        uses_rs1_o  = 1'b1;
        uses_rs2_o  = 1'b1;
        writes_rd_o = 1'b1;
        case ({f7, f3})
          {F7_BASE, 3'b000}: op_o = OP_ADD;
          {F7_ALT,  3'b000}: op_o = OP_SUB;
          {F7_BASE, 3'b001}: op_o = OP_SLL;
          {F7_BASE, 3'b010}: op_o = OP_SLT;
          {F7_BASE, 3'b011}: op_o = OP_SLTU;
          {F7_BASE, 3'b100}: op_o = OP_XOR;
          {F7_BASE, 3'b101}: op_o = OP_SRL;
          {F7_ALT,  3'b101}: op_o = OP_SRA;
          {F7_BASE, 3'b110}: op_o = OP_OR;
          {F7_BASE, 3'b111}: op_o = OP_AND;
          default:           op_o = OP_EMPTY;
        endcase
      end
      default: op_o = OP_EMPTY;
    endcase
    if (op_o == OP_EMPTY) begin
      imm_o       = '0;
      is_ls_o     = 1'b0;
      uses_rs1_o  = 1'b0;
      uses_rs2_o  = 1'b0;
      writes_rd_o = 1'b0;
    end
  end

endmodule

// File: rtl/decode_dispatch_unit.sv
// Buffered decode/dispatch: instruction queue, head decode, operand resolution via
// regfile/ROB/CDB, and one registered dispatch per cycle to ROB plus RS or LSB.
module decode_dispatch_unit
  import decode_dispatch_unit_pkg::*;
#(
  parameter int IQ_DEPTH = 8,
  parameter int ADDR_W   = 32,
  parameter int TAG_W    = 4,
  parameter int OPT_W    = 6
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear_in,
  input  logic              inst_valid_in,
  input  logic [31:0]       inst_in,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              iq_full_out,
  output logic [4:0]        rs1_pos_out,
  output logic [4:0]        rs2_pos_out,
  input  logic [31:0]       rs1_data_in,
  input  logic [31:0]       rs2_data_in,
  input  logic [TAG_W-1:0]  rs1_tag_in,
  input  logic [TAG_W-1:0]  rs2_tag_in,
  output logic [TAG_W-1:0]  rob_rs1_tag_out,
  output logic [TAG_W-1:0]  rob_rs2_tag_out,
  input  logic              rob_rs1_ready_in,
  input  logic              rob_rs2_ready_in,
  input  logic [31:0]       rob_rs1_data_in,
  input  logic [31:0]       rob_rs2_data_in,
  input  logic              rob_free_in,
  input  logic [TAG_W-1:0]  rob_tag_in,
  input  logic              rs_free_in,
  input  logic              lsb_free_in,
  input  logic              cdb_valid_in,
  input  logic [TAG_W-1:0]  cdb_tag_in,
  input  logic [31:0]       cdb_data_in,
  output logic              issue_rob_out,
  output logic              issue_rs_out,
  output logic              issue_lsb_out,
  output logic              rename_en_out,
  output logic [4:0]        rename_rd_out,
  output logic [TAG_W-1:0]  rename_tag_out,
  output logic [OPT_W-1:0]  op_out,
  output logic [4:0]        rd_out,
  output logic [TAG_W-1:0]  dest_out,
  output logic [TAG_W-1:0]  q1_out,
  output logic [31:0]       v1_out,
  output logic [TAG_W-1:0]  q2_out,
  output logic [31:0]       v2_out,
  output logic [31:0]       imm_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              illegal_out
);

  localparam int PTR_W = $clog2(IQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [TAG_W-1:0] READY_TAG = TAG_W'(EMPTY_TAG);

  logic [31:0]       iq_inst_q [IQ_DEPTH];
  logic [ADDR_W-1:0] iq_pc_q   [IQ_DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic issue_rob_q, issue_rs_q, issue_lsb_q, rename_en_q, illegal_q;
  logic [OPT_W-1:0]  op_q;
  logic [4:0]        rd_q;
  logic [TAG_W-1:0]  dest_q, q1_q, q2_q;
  logic [31:0]       v1_q, v2_q, imm_q;
  logic [ADDR_W-1:0] pc_q;

  logic [31:0]       head_inst;
  logic [ADDR_W-1:0] head_pc;
  logic [4:0]        rs1_idx, rs2_idx, rd_idx;
  op_t               dec_op;
  logic [31:0]       dec_imm;
  logic              dec_is_ls, dec_uses_rs1, dec_uses_rs2, dec_writes_rd;
  logic [TAG_W+31:0] opnd1, opnd2;
  logic [TAG_W-1:0]  q2_sel;
  logic [31:0]       v2_sel;
  logic              is_shift, has_head, head_legal, unit_free, active;
  logic              do_issue, do_drop, do_pop, do_push;

  assign head_inst = iq_inst_q[head_q];
  assign head_pc   = iq_pc_q[head_q];
  assign rs1_idx   = head_inst[19:15];
  assign rs2_idx   = head_inst[24:20];
  assign rd_idx    = head_inst[11:7];

  decode_dispatch_unit_inst_decode u_inst_decode (
    .inst_i      (head_inst),
    .op_o        (dec_op),
    .imm_o       (dec_imm),
    .is_ls_o     (dec_is_ls),
    .uses_rs1_o  (dec_uses_rs1),
    .uses_rs2_o  (dec_uses_rs2),
    .writes_rd_o (dec_writes_rd)
  );

  assign rs1_pos_out     = rs1_idx;
  assign rs2_pos_out     = rs2_idx;
  assign rob_rs1_tag_out = rs1_tag_in;
  assign rob_rs2_tag_out = rs2_tag_in;

  // Returns {tag, value}; a zero tag means the value is final.
  function automatic logic [TAG_W+31:0] resolve(
    input logic             used,
    input logic [TAG_W-1:0] rf_tag,
    input logic [31:0]      rf_data,
    input logic             rob_ready,
    input logic [31:0]      rob_data,
    input logic             cdb_valid,
    input logic [TAG_W-1:0] cdb_tag,
    input logic [31:0]      cdb_data
  );
    if (!used)                                return '0;
    else if (rf_tag == READY_TAG)             return {READY_TAG, rf_data};
    else if (rob_ready)                       return {READY_TAG, rob_data};
    else if (cdb_valid && cdb_tag == rf_tag)  return {READY_TAG, cdb_data};
    else                                      return {rf_tag, 32'b0};
  endfunction

  assign opnd1 = resolve(dec_uses_rs1, rs1_tag_in, rs1_data_in, rob_rs1_ready_in,
                         rob_rs1_data_in, cdb_valid_in, cdb_tag_in, cdb_data_in);
  assign opnd2 = resolve(dec_uses_rs2, rs2_tag_in, rs2_data_in, rob_rs2_ready_in,
                         rob_rs2_data_in, cdb_valid_in, cdb_tag_in, cdb_data_in);

  assign is_shift = (dec_op == OP_SLLI) || (dec_op == OP_SRLI) || (dec_op == OP_SRAI);
  assign q2_sel   = is_shift ? READY_TAG : opnd2[TAG_W+31:32];
  assign v2_sel   = is_shift ? {27'b0, rs2_idx} : opnd2[31:0];

  assign iq_full_out = (count_q == CNT_W'(IQ_DEPTH));
  assign active      = rdy_in && !clear_in;
  assign has_head    = (count_q != '0);
  assign head_legal  = (dec_op != OP_EMPTY);
  assign unit_free   = dec_is_ls ? lsb_free_in : rs_free_in;
  assign do_issue    = active && has_head && head_legal && rob_free_in && unit_free;
  // Undecodable heads are discarded even when downstream is busy so they never block the queue.
  assign do_drop     = active && has_head && !head_legal;
  assign do_pop      = do_issue || do_drop;
  assign do_push     = active && inst_valid_in && !iq_full_out;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_in) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) tail_d = tail_q + PTR_W'(1);
      if (do_pop)  head_d = head_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && do_push) begin
      iq_inst_q[tail_q] <= inst_in;
      iq_pc_q[tail_q]   <= pc_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      issue_rob_q <= 1'b0;
      issue_rs_q  <= 1'b0;
      issue_lsb_q <= 1'b0;
      rename_en_q <= 1'b0;
      illegal_q   <= 1'b0;
      op_q        <= '0;
      rd_q        <= '0;
      dest_q      <= '0;
      q1_q        <= '0;
      v1_q        <= '0;
      q2_q        <= '0;
      v2_q        <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
    end else if (rdy_in) begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      issue_rob_q <= do_issue;
      issue_rs_q  <= do_issue && !dec_is_ls;
      issue_lsb_q <= do_issue && dec_is_ls;
      rename_en_q <= do_issue && dec_writes_rd && (rd_idx != 5'd0);
      illegal_q   <= do_drop;
      if (do_issue) begin
        op_q   <= OPT_W'(dec_op);
        rd_q   <= dec_writes_rd ? rd_idx : 5'd0;
        dest_q <= rob_tag_in;
        q1_q   <= opnd1[TAG_W+31:32];
        v1_q   <= opnd1[31:0];
        q2_q   <= q2_sel;
        v2_q   <= v2_sel;
        imm_q  <= dec_imm;
        pc_q   <= head_pc;
      end
    end
  end

  // Strobes are held in registers across a freeze but must not be seen while frozen.
  assign issue_rob_out  = issue_rob_q && rdy_in;
  assign issue_rs_out   = issue_rs_q && rdy_in;
  assign issue_lsb_out  = issue_lsb_q && rdy_in;
  assign rename_en_out  = rename_en_q && rdy_in;
  assign illegal_out    = illegal_q && rdy_in;
  assign rename_rd_out  = rd_q;
  assign rename_tag_out = dest_q;
  assign op_out         = op_q;
  assign rd_out         = rd_q;
  assign dest_out       = dest_q;
  assign q1_out         = q1_q;
  assign v1_out         = v1_q;
  assign q2_out         = q2_q;
  assign v2_out         = v2_q;
  assign imm_out        = imm_q;
  assign pc_out         = pc_q;

endmodule

// File: tb/tb_decode_dispatch_unit.sv
// Self-checking bench for decode_dispatch_unit: expected dispatch payloads are queued
// when instructions are pushed and compared by a monitor when the issue strobes fire.
module tb_decode_dispatch_unit;
  import decode_dispatch_unit_pkg::*;

  localparam int EXP_W = 164;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, clear_in, inst_valid_in;
  logic [31:0] inst_in, pc_in;
  logic        iq_full_out;
  logic [4:0]  rs1_pos_out, rs2_pos_out;
  logic [31:0] rs1_data_in, rs2_data_in;
  logic [3:0]  rs1_tag_in, rs2_tag_in, rob_rs1_tag_out, rob_rs2_tag_out;
  logic        rob_rs1_ready_in, rob_rs2_ready_in;
  logic [31:0] rob_rs1_data_in, rob_rs2_data_in;
  logic        rob_free_in, rs_free_in, lsb_free_in, cdb_valid_in;
  logic [3:0]  rob_tag_in, cdb_tag_in;
  logic [31:0] cdb_data_in;
  logic        issue_rob_out, issue_rs_out, issue_lsb_out, rename_en_out, illegal_out;
  logic [4:0]  rename_rd_out, rd_out;
  logic [3:0]  rename_tag_out, dest_out, q1_out, q2_out;
  logic [5:0]  op_out;
  logic [31:0] v1_out, v2_out, imm_out, pc_out;

  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] mon_obs, mon_exp;
  int total = 0;
  int bad   = 0;

  decode_dispatch_unit dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .inst_valid_in(inst_valid_in), .inst_in(inst_in), .pc_in(pc_in),
    .iq_full_out(iq_full_out), .rs1_pos_out(rs1_pos_out), .rs2_pos_out(rs2_pos_out),
    .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
    .rs1_tag_in(rs1_tag_in), .rs2_tag_in(rs2_tag_in),
    .rob_rs1_tag_out(rob_rs1_tag_out), .rob_rs2_tag_out(rob_rs2_tag_out),
    .rob_rs1_ready_in(rob_rs1_ready_in), .rob_rs2_ready_in(rob_rs2_ready_in),
    .rob_rs1_data_in(rob_rs1_data_in), .rob_rs2_data_in(rob_rs2_data_in),
    .rob_free_in(rob_free_in), .rob_tag_in(rob_tag_in),
    .rs_free_in(rs_free_in), .lsb_free_in(lsb_free_in),
    .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_data_in(cdb_data_in),
    .issue_rob_out(issue_rob_out), .issue_rs_out(issue_rs_out), .issue_lsb_out(issue_lsb_out),
    .rename_en_out(rename_en_out), .rename_rd_out(rename_rd_out), .rename_tag_out(rename_tag_out),
    .op_out(op_out), .rd_out(rd_out), .dest_out(dest_out),
    .q1_out(q1_out), .v1_out(v1_out), .q2_out(q2_out), .v2_out(v2_out),
    .imm_out(imm_out), .pc_out(pc_out), .illegal_out(illegal_out)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // kind = {issue_rob, issue_rs, issue_lsb}
  function automatic logic [EXP_W-1:0] mk(
    input logic [2:0] kind, input logic ren, input op_t op, input logic [4:0] rd,
    input logic [3:0] dest, input logic [3:0] q1, input logic [31:0] v1,
    input logic [3:0] q2, input logic [31:0] v2, input logic [31:0] imm,
    input logic [31:0] pc);
    logic [5:0] opv;
    opv = op;
    return {kind, ren, opv, rd, rd, dest, dest, q1, v1, q2, v2, imm, pc};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_idle;
    rdy_in = 1'b1; clear_in = 1'b0; inst_valid_in = 1'b0; inst_in = '0; pc_in = '0;
    rs1_data_in = '0; rs2_data_in = '0; rs1_tag_in = '0; rs2_tag_in = '0;
    rob_rs1_ready_in = 1'b0; rob_rs2_ready_in = 1'b0;
    rob_rs1_data_in = '0; rob_rs2_data_in = '0;
    rob_free_in = 1'b1; rob_tag_in = 4'd1; rs_free_in = 1'b1; lsb_free_in = 1'b1;
    cdb_valid_in = 1'b0; cdb_tag_in = '0; cdb_data_in = '0;
  endtask

  task automatic push_inst(input logic [31:0] inst, input logic [31:0] pc);
    inst_valid_in = 1'b1;
    inst_in = inst;
    pc_in = pc;
    tick;
    inst_valid_in = 1'b0;
  endtask

  task automatic drain;
    for (int i = 0; i < 30; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    tick;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst_in && (issue_rob_out || issue_rs_out || issue_lsb_out)) begin
      mon_obs = {issue_rob_out, issue_rs_out, issue_lsb_out, rename_en_out, op_out, rd_out,
                 rename_rd_out, dest_out, rename_tag_out, q1_out, v1_out, q2_out, v2_out,
                 imm_out, pc_out};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL issue_unexpected got=%h want=no_issue", mon_obs);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_obs !== mon_exp) begin
          bad++;
          $display("FAIL issue_payload got=%h want=%h", mon_obs, mon_exp);
        end
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset;
    set_idle;
    rst_in = 1'b1;
    repeat (3) tick;
    total++;
    if ({issue_rob_out, issue_rs_out, issue_lsb_out, rename_en_out, illegal_out, iq_full_out} !== 6'b0) begin
      bad++; $display("FAIL reset_strobes got=%b want=000000",
        {issue_rob_out, issue_rs_out, issue_lsb_out, rename_en_out, illegal_out, iq_full_out});
    end
    total++;
    if ({op_out, dest_out, v1_out, imm_out, pc_out} !== '0) begin
      bad++; $display("FAIL reset_payload got=%h want=0", {op_out, dest_out, v1_out, imm_out, pc_out});
    end
    rst_in = 1'b0;
    repeat (2) tick;
    total++;
    if (issue_rob_out !== 1'b0) begin
      bad++; $display("FAIL empty_no_issue got=%b want=0", issue_rob_out);
    end
  endtask

  task automatic test_addi;
    set_idle;
    rob_tag_in = 4'd5;
    rs2_tag_in = 4'd2; rs2_data_in = 32'h77;
    exp_q.push_back(mk(3'b110, 1'b1, OP_ADDI, 5'd1, 4'd5, 4'd0, 32'd0, 4'd0, 32'd0, 32'd5, 32'h1000));
    push_inst(addi(5'd1, 5'd0, 12'd5), 32'h1000);
    tick;
    total++;
    if ({issue_rob_out, issue_rs_out, issue_lsb_out} !== 3'b110) begin
      bad++; $display("FAIL addi_latency got=%b want=110", {issue_rob_out, issue_rs_out, issue_lsb_out});
    end
    drain;
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL addi_drain left=%0d want=0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_load_cdb;
    set_idle;
    rob_tag_in = 4'd6;
    rs_free_in = 1'b0;
    rs1_tag_in = 4'd3; rob_rs1_ready_in = 1'b0;
    cdb_valid_in = 1'b1; cdb_tag_in = 4'd3; cdb_data_in = 32'h100;
    exp_q.push_back(mk(3'b101, 1'b1, OP_LW, 5'd2, 4'd6, 4'd0, 32'h100, 4'd0, 32'd0, 32'd8, 32'h1004));
    push_inst({12'd8, 5'd1, 3'b010, 5'd2, 7'b0000011}, 32'h1004);
    drain;
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL lw_drain left=%0d want=0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_operands;
    logic [31:0] add_inst;
    add_inst = {7'b0, 5'd7, 5'd6, 3'b000, 5'd5, 7'b0110011};
    // ROB-ready rs1, rs2 still pending with a non-matching CDB broadcast
    set_idle;
    rob_tag_in = 4'd2;
    rs1_tag_in = 4'd2; rob_rs1_ready_in = 1'b1; rob_rs1_data_in = 32'hAAAA;
    rs2_tag_in = 4'd4; cdb_valid_in = 1'b1; cdb_tag_in = 4'd5; cdb_data_in = 32'hEEEE;
    exp_q.push_back(mk(3'b110, 1'b1, OP_ADD, 5'd5, 4'd2, 4'd0, 32'hAAAA, 4'd4, 32'd0, 32'd0, 32'h1008));
    push_inst(add_inst, 32'h1008);
    drain;
    // regfile value wins over ROB; ROB wins over CDB
    set_idle;
    rob_tag_in = 4'd3;
    rs1_tag_in = 4'd0; rs1_data_in = 32'h1234; rob_rs1_ready_in = 1'b1; rob_rs1_data_in = 32'h9999;
    rs2_tag_in = 4'd6; rob_rs2_ready_in = 1'b1; rob_rs2_data_in = 32'hBBBB;
    cdb_valid_in = 1'b1; cdb_tag_in = 4'd6; cdb_data_in = 32'hCCCC;
    exp_q.push_back(mk(3'b110, 1'b1, OP_ADD, 5'd5, 4'd3, 4'd0, 32'h1234, 4'd0, 32'hBBBB, 32'd0, 32'h100C));
    push_inst(add_inst, 32'h100C);
    drain;
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL operand_drain left=%0d want=0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_fill_wrap;
    set_idle;
    rob_free_in = 1'b0;
    rob_tag_in = 4'd7;
    rs1_data_in = 32'h55;
    for (int k = 1; k <= 9; k++) begin
      if (k <= 8)
        exp_q.push_back(mk(3'b110, 1'b1, OP_ADDI, 5'(k), 4'd7, 4'd0, 32'h55, 4'd0, 32'd0,
                           32'(k), 32'h2000 + 32'(4 * k)));
      push_inst(addi(5'(k), 5'd0, 12'(k)), 32'h2000 + 32'(4 * k));
      if (k == 7) begin
        total++;
        if (iq_full_out !== 1'b0) begin
          bad++; $display("FAIL full_at7 got=%b want=0", iq_full_out);
        end
      end
      if (k >= 8) begin
        total++;
        if (iq_full_out !== 1'b1) begin
          bad++; $display("FAIL full_at%0d got=%b want=1", k, iq_full_out);
        end
      end
    end
    rob_free_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      total++;
      if (issue_rob_out !== 1'b1) begin
        bad++; $display("FAIL burst_cycle%0d got=%b want=1", i, issue_rob_out);
      end
    end
    tick;
    total++;
    if (issue_rob_out !== 1'b0) begin
      bad++; $display("FAIL ninth_dropped got=%b want=0", issue_rob_out);
    end
    drain;
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL fill_drain left=%0d want=0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_back_to_back;
    set_idle;
    rob_tag_in = 4'd8;
    rs1_data_in = 32'h42;
    rs2_tag_in = 4'd9; rs2_data_in = 32'hDEAD;
    exp_q.push_back(mk(3'b110, 1'b1, OP_SRAI, 5'd3, 4'd8, 4'd0, 32'h42, 4'd0, 32'd7, 32'd7, 32'h3000));
    exp_q.push_back(mk(3'b110, 1'b0, OP_BEQ, 5'd0, 4'd8, 4'd0, 32'h42, 4'd9, 32'd0, 32'd16, 32'h3004));
    push_inst({7'b0100000, 5'd7, 5'd4, 3'b101, 5'd3, 7'b0010011}, 32'h3000);
    push_inst({1'b0, 6'b0, 5'd2, 5'd1, 3'b000, 4'b1000, 1'b0, 7'b1100011}, 32'h3004);
    total++;
    if (issue_rob_out !== 1'b1) begin
      bad++; $display("FAIL b2b_first got=%b want=1", issue_rob_out);
    end
    tick;
    total++;
    if ({issue_rob_out, rename_en_out} !== 2'b10) begin
      bad++; $display("FAIL b2b_second got=%b want=10", {issue_rob_out, rename_en_out});
    end
    drain;
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL b2b_drain left=%0d want=0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_flush;
    set_idle;
    rob_free_in = 1'b0;
    for (int k = 0; k < 4; k++) push_inst(addi(5'd9, 5'd0, 12'($urandom_range(1, 100))), 32'h4000 + 32'(4 * k));
    clear_in = 1'b1;
    push_inst(addi(5'd10, 5'd0, 12'd1), 32'h4100);
    clear_in = 1'b0;
    rob_free_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      total++;
      if (issue_rob_out !== 1'b0) begin
        bad++; $display("FAIL flush_no_issue%0d got=%b want=0", i, issue_rob_out);
      end
    end
    total++;
    if (op_out !== 6'(OP_BEQ)) begin
      bad++; $display("FAIL flush_payload_hold got=%0d want=%0d", op_out, 6'(OP_BEQ));
    end
    rob_tag_in = 4'd4;
    exp_q.push_back(mk(3'b110, 1'b1, OP_ADDI, 5'd11, 4'd4, 4'd0, 32'd0, 4'd0, 32'd0, 32'd33, 32'h4200));
    push_inst(addi(5'd11, 5'd0, 12'd33), 32'h4200);
    drain;
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL flush_drain left=%0d want=0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_freeze;
    set_idle;
    rob_free_in = 1'b0;
    rob_tag_in = 4'd12;
    exp_q.push_back(mk(3'b110, 1'b1, OP_ADDI, 5'd12, 4'd12, 4'd0, 32'd0, 4'd0, 32'd0, 32'd77, 32'h5000));
    push_inst(addi(5'd12, 5'd0, 12'd77), 32'h5000);
    rdy_in = 1'b0;
    rob_free_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      total++;
      if (issue_rob_out !== 1'b0) begin
        bad++; $display("FAIL freeze_no_issue%0d got=%b want=0", i, issue_rob_out);
      end
    end
    rdy_in = 1'b1;
    drain;
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL freeze_drain left=%0d want=0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_illegal_and_reset;
    set_idle;
    push_inst(32'h0000_0000, 32'h6000);
    tick;
    total++;
    if ({illegal_out, issue_rob_out, issue_rs_out, issue_lsb_out} !== 4'b1000) begin
      bad++; $display("FAIL illegal_pulse got=%b want=1000", {illegal_out, issue_rob_out, issue_rs_out, issue_lsb_out});
    end
    tick;
    total++;
    if (illegal_out !== 1'b0) begin
      bad++; $display("FAIL illegal_once got=%b want=0", illegal_out);
    end
    rob_free_in = 1'b0;
    push_inst(addi(5'd13, 5'd0, 12'd1), 32'h6004);
    push_inst(addi(5'd14, 5'd0, 12'd2), 32'h6008);
    rst_in = 1'b1;
    tick;
    total++;
    if ({op_out, dest_out, v1_out, v2_out, imm_out, pc_out, iq_full_out, issue_rob_out, illegal_out} !== '0) begin
      bad++; $display("FAIL midstall_reset got=%h want=0",
        {op_out, dest_out, v1_out, v2_out, imm_out, pc_out, iq_full_out, issue_rob_out, illegal_out});
    end
    rst_in = 1'b0;
    rob_free_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      total++;
      if (issue_rob_out !== 1'b0) begin
        bad++; $display("FAIL reset_emptied%0d got=%b want=0", i, issue_rob_out);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_in = 1'b1;
    set_idle;
    test_reset;
    test_addi;
    test_load_cdb;
    test_operands;
    test_fill_wrap;
    test_back_to_back;
    test_flush;
    test_freeze;
    test_illegal_and_reset;
    repeat (2) tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
